// File: rtl/sfifo_burst_drain.sv
// sfifo_burst_drain: drains an asynchronous-read FIFO as fixed-length valid/ready bursts,
// with a timeout that flushes a partial burst.
module sfifo_burst_drain #(
  parameter int BW        = 8,
  parameter int LGFLEN    = 4,
  parameter int LGTIMEOUT = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  output logic                 o_fifo_rd,
  input  logic [BW-1:0]        i_fifo_data,
  input  logic                 i_fifo_empty,
  input  logic [LGFLEN:0]      i_fifo_fill,
  input  logic [LGFLEN:0]      i_burst_len,
  input  logic [LGTIMEOUT-1:0] i_timeout,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [BW-1:0]        o_data,
  output logic                 o_last,
  output logic                 o_busy
);
  localparam logic [LGFLEN:0] FLEN = {1'b1, {LGFLEN{1'b0}}};
  localparam logic [LGFLEN:0] ONE  = {{LGFLEN{1'b0}}, 1'b1};
  typedef enum logic {IDLE, BURST} state_t;
  state_t               state;
  logic [LGTIMEOUT-1:0] timer;
  logic [LGFLEN:0]      remaining;
  logic [LGFLEN:0]      eff_len;
  always_comb eff_len = (i_burst_len == '0) ? ONE : (i_burst_len > FLEN) ? FLEN : i_burst_len;
  // Pops only when the output register is free or being emptied this cycle.
  assign o_fifo_rd = !i_reset && (state == BURST) && (remaining != '0) && !i_fifo_empty
                     && (!o_valid || i_ready);
  assign o_busy = (state == BURST) || o_valid;
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= IDLE;
      timer     <= '0;
      remaining <= '0;
      o_valid   <= 1'b0;
      o_last    <= 1'b0;
      o_data    <= '0;
    end else begin
      if (o_fifo_rd) begin
        o_data    <= i_fifo_data;
        o_valid   <= 1'b1;
        o_last    <= (remaining == ONE);
        remaining <= remaining - ONE;
        if (remaining == ONE) state <= IDLE;
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
        o_last  <= 1'b0;
      end
      if (state == IDLE) begin
        timer <= i_fifo_empty ? '0 : (&timer ? timer : timer + 1'b1);
        if (i_fifo_fill >= eff_len) begin
          state     <= BURST;
          remaining <= eff_len;
          timer     <= '0;
        end else if (i_timeout != '0 && timer >= i_timeout && !i_fifo_empty) begin
          state     <= BURST;
          remaining <= i_fifo_fill;
          timer     <= '0;
        end
      end
    end
  end
endmodule
